// File: rtl/bcd_palindrome_pkg.sv
// Shared types, sizing and the digit-ordering helper for the BCD palindrome transmitter.
package bcd_palindrome_pkg;

  localparam int unsigned MAX_DIGITS_DEFAULT = 16;
  // Wide enough to hold a digit count of 0..MAX_DIGITS_DEFAULT.
  localparam int unsigned LEN_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_e;

  // Source digit index for output position i. When mirroring, the second half of the word
  // walks back down through the first ceil(len/2) digits.
  function automatic logic [LEN_W-1:0] mirror_index(input logic [LEN_W-1:0] i,
                                                    input logic [LEN_W-1:0] len,
                                                    input logic             mirror);
    logic [LEN_W-1:0] h;
    h = (len + LEN_W'(1)) >> 1;
    if (mirror && (i >= h)) begin
      return len - i - LEN_W'(1);
    end
    return i;
  endfunction

endpackage

// File: rtl/bcd_seed_checker.sv
// Combinational check that every digit the transmitter will actually use is a legal BCD digit.
// Digits beyond the used range are ignored.
module bcd_seed_checker
  import bcd_palindrome_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = MAX_DIGITS_DEFAULT
) (
  input  logic [4*MAX_DIGITS-1:0] seed,
  input  logic [LEN_W-1:0]        len,
  input  logic                    mirror,
  output logic                    ok
);

  logic [LEN_W-1:0] used;

  // Mirrored words only read the first ceil(len/2) digits.
  always_comb begin
    used = mirror ? ((len + LEN_W'(1)) >> 1) : len;
    ok   = 1'b1;
    for (int k = 0; k < int'(MAX_DIGITS); k++) begin
      if ((LEN_W'(k) < used) && (seed[4*MAX_DIGITS-1-4*k -: 4] > 4'd9)) begin
        ok = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bcd_palindrome_tx.sv
// Serial BCD digit transmitter: emits a latched seed one digit per ready/valid transfer,
// either verbatim or mirrored into a palindrome.
// Optional feature: define BCD_CHECK_EN to reject starts whose used digits exceed 9.
module bcd_palindrome_tx
  import bcd_palindrome_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = MAX_DIGITS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4*MAX_DIGITS-1:0] seed,
  input  logic [LEN_W-1:0]        len,
  input  logic                    mirror,
  input  logic                    digit_ready,
  output logic [3:0]              digit_out,
  output logic                    digit_valid,
  output logic [LEN_W-1:0]        len_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned SEED_W = 4 * MAX_DIGITS;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic              mirror_q, mirror_d;
  logic [3:0]        digit_q, digit_d;
  logic              err_q, err_d;

  logic              len_ok;
  logic              bcd_ok;
  logic              start_ok;
  logic              last;
  logic [LEN_W-1:0]  next_src;
  logic [SEED_W-1:0] next_shifted;
  logic [3:0]        next_digit;

  assign len_ok   = (len != '0) && (len <= LEN_W'(MAX_DIGITS));
  assign start_ok = len_ok && bcd_ok;

`ifdef BCD_CHECK_EN
  bcd_seed_checker #(
    .MAX_DIGITS (MAX_DIGITS)
  ) u_checker (
    .seed   (seed),
    .len    (len),
    .mirror (mirror),
    .ok     (bcd_ok)
  );
`else
  assign bcd_ok = 1'b1;
`endif

  // Look up the digit for the following position so digit_out can be registered.
  always_comb begin
    last         = (idx_q == (len_q - LEN_W'(1)));
    next_src     = mirror_index(idx_q + LEN_W'(1), len_q, mirror_q);
    next_shifted = seed_q << {next_src, 2'b00};
    next_digit   = next_shifted[SEED_W-1 -: 4];
  end

  // Next-state logic: start acceptance, transfer stepping and the one-cycle DONE state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    seed_d   = seed_q;
    mirror_d = mirror_q;
    digit_d  = digit_q;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            state_d  = SEND;
            idx_d    = '0;
            len_d    = len;
            seed_d   = seed;
            mirror_d = mirror;
            // Position 0 always maps to digit 0, mirrored or not.
            digit_d  = seed[SEED_W-1 -: 4];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (digit_ready) begin
          if (last) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            digit_d = next_digit;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      seed_q   <= '0;
      mirror_q <= 1'b0;
      digit_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      seed_q   <= seed_d;
      mirror_q <= mirror_d;
      digit_q  <= digit_d;
      err_q    <= err_d;
    end
  end

  // Outputs decode straight from registers, so valid never depends on ready.
  always_comb begin
    digit_out   = digit_q;
    digit_valid = (state_q == SEND);
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    err         = err_q;
    len_out     = len_q;
  end

endmodule

// File: doc/bcd_palindrome_tx.md
# bcd_palindrome_tx

Serial BCD digit transmitter: the sending end of the serial-digit interface our palindrome detector consumes. Accepts a parallel-loaded, packed BCD seed and emits it one 4-bit digit per transfer, either verbatim or mirrored into a full palindrome. It drives the digit stream and digit count into the detector, and serves as the stimulus source for detector regression.

## Interface
- MAX_DIGITS, 16: maximum digits per word. Seed width is 4*MAX_DIGITS.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a transmission. Sampled only in IDLE.
- seed  in  64  packed BCD digits. Digit 0 is seed[63:60], digit k is seed[63-4k -: 4].
- len  in  5  total digits to emit. Legal range 1..16.
- mirror  in  1  1 = emit a palindrome built from the seed; 0 = emit seed digits verbatim.
- digit_ready  in  1  downstream accepts the current digit.
- digit_out  out  4  current digit.
- digit_valid  out  1  digit_out is valid.
- len_out  out  5  latched len, held for the downstream digit count.
- busy  out  1  transmission in progress.
- done  out  1  one-cycle pulse after the last digit transfer.
- err  out  1  one-cycle pulse when start is rejected.

## Operation
- States and transitions:
  - IDLE -> SEND on an accepted start.
  - SEND -> DONE after the transfer of digit len-1.
  - DONE -> IDLE unconditionally.
- Start acceptance in IDLE with start=1:
  - If 1 <= len <= 16 (and the BCD check passes, if enabled), latch seed, len and mirror, clear the index to 0, and go to SEND.
  - Otherwise pulse err and stay in IDLE.
- start is ignored in SEND and DONE. seed, len and mirror are don't-care after acceptance.
- Output index i, for i in 0..len-1:
  - mirror=0: digit_out = digit i.
  - mirror=1: with h = ceil(len/2), digit_out = digit i for i < h, and digit (len-1-i) for i >= h.
  - Only digits 0..h-1 are used when mirror=1, and only 0..len-1 when mirror=0. Unused seed digits are ignored.
- A transfer occurs on a cycle where digit_valid=1 and digit_ready=1. The index then increments.
- While digit_valid=1 and digit_ready=0, digit_out is held stable.
- len_out is updated on acceptance and holds until the next accepted start.
- Index width is 5 bits. The index never wraps because SEND exits at len-1.

## Timing
- Reset values: state IDLE, digit_out=0, digit_valid=0, len_out=0, busy=0, done=0, err=0, index=0.
- Accepted start at edge t:
  - busy=1 and digit_valid=1 with digit 0 from t+1.
  - With digit_ready held at 1, digit i is presented in cycle t+1+i.
- Last transfer at edge k:
  - At k+1, digit_valid=0, done=1 and busy stays 1 (DONE state).
  - At k+2, busy=0 and done=0 (IDLE).
  - Minimum start-to-start spacing is len+2 cycles.
- Rejected start at edge t: err=1 during t+1 only. busy stays 0.
- digit_valid is registered. It never depends combinationally on digit_ready.
- Reset asserted in any state, including mid-SEND: on the next edge all outputs take their reset values and the partial word is abandoned. No done pulse is produced.
- start held high across DONE is not accepted until IDLE, one cycle after done.

## Configuration
- BCD_CHECK_EN defined: on start, every used seed digit must be <= 9. Any used digit > 9 rejects the start with an err pulse and no transmission.
- BCD_CHECK_EN undefined: digits pass through unchecked, and only the len range is checked for err.

## Structure
- Package bcd_palindrome_pkg holds:
  - the state enum {IDLE, SEND, DONE};
  - the MAX_DIGITS default;
  - the function mirror_index(i, len, mirror), which returns the source digit index.
- One sub-module, bcd_seed_checker: combinational check that the used digits are <= 9, driven by len and mirror. It is instantiated only under BCD_CHECK_EN.

## Test plan
- Odd palindrome: seed=64'h1230_0000_0000_0000, len=5, mirror=1, ready=1 -> digits 1,2,3,2,1 on t+1..t+5, done at t+6, busy low at t+7, len_out=5.
- Even palindrome plus back-pressure: seed=64'h9870_0000_0000_0000, len=6, mirror=1, ready low on alternate cycles -> digits 9,8,7,7,8,9, each held stable while ready=0, exactly 6 transfers.
- Verbatim full word: seed=64'h0123_4567_8901_2345, len=16, mirror=0 -> 16 digits in order 0..5, start pulsed mid-SEND ignored, single done.
- Illegal length: len=0, then len=17 -> err pulse one cycle each, digit_valid and busy stay 0.
- BCD check: seed=64'h1A00_0000_0000_0000, len=3, mirror=1 -> err with BCD_CHECK_EN defined; digits 1,A,1 without it.
- Reset mid-word: reset during digit 2 of a len=8 send -> next cycle all outputs 0, no done pulse, a fresh start transmits correctly.
